// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input conditioning, 11-bit frame
// deserialiser with start/parity/stop checks and stall timeout,
// feeding a first-word-fall-through byte FIFO with a valid/ready read port.
module ps2_rx_fifo #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int FIFO_DEPTH   = 8,
    parameter int CHECK_PARITY = 1
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [FW-1:0] FMAX  = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- input conditioning ----------------
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_prev;
    logic [FW-1:0] run_q;
    logic          fall;

    // Two-flop synchronisers; idle bus is high so reset to 1.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Deglitch: the filtered clock follows only after FILTER_LEN disagreeing cycles in a row.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            clk_f      <= 1'b1;
            clk_f_prev <= 1'b1;
            run_q      <= '0;
        end else begin
            clk_f_prev <= clk_f;
            if (clk_s2 != clk_f) begin
                if (run_q == FMAX) begin
                    clk_f <= clk_s2;
                    run_q <= '0;
                end else begin
                    run_q <= run_q + FW'(1);
                end
            end else begin
                run_q <= '0;
            end
        end
    end

    assign fall = clk_f_prev & ~clk_f;

    // ---------------- frame FSM ----------------
    state_t        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push, perr, ferr;

    // FSM and frame registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state: sample events advance the frame; otherwise the stall timer runs.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        push    = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    // A high data line at a falling edge is a spurious edge, not a start bit.
                    if (!dat_s2) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {dat_s2, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
                STOP: begin
                    // Bad stop bit outranks bad parity so a frame yields at most one error.
                    if (!dat_s2)
                        ferr = 1'b1;
                    else if ((CHECK_PARITY != 0) && !(^{shreg_q, par_q}))
                        perr = 1'b1;
                    else
                        push = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMAX) begin
                ferr    = 1'b1;
                state_d = IDLE;
                tmo_d   = '0;
                bit_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          full, pop, wr;

    assign full     = (count_q == DEPTH);
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign wr       = push & (~full | pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;
    assign count    = count_q;

    // Storage array; contents are don't-care while their slot is unoccupied.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shreg_q;
    end

    // Pointers, occupancy and one-cycle error pulses.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= perr;
            frame_err  <= ferr;
            overflow   <= push & full & ~pop;
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: one task per scenario, inline checks.
module tb_ps2_rx_fifo;
    localparam int FL   = 4;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0, areset = 1'b1;
    logic       ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic       rd_ready = 1'b0, rd_ready_np = 1'b1;
    logic [7:0] rd_data, rd_data_np;
    logic       rd_valid, rd_valid_np;
    logic [3:0] count, count_np;
    logic       parity_err, frame_err, overflow;
    logic       parity_err_np, frame_err_np, overflow_np;

    int checks = 0, failures = 0;
    int pe_n = 0, fe_n = 0, ov_n = 0;
    int lat = 0;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(8), .CHECK_PARITY(1)) dut (
        .clk(clk), .areset(areset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow));

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(8), .CHECK_PARITY(0)) dut_np (
        .clk(clk), .areset(areset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd_data(rd_data_np), .rd_valid(rd_valid_np), .rd_ready(rd_ready_np), .count(count_np),
        .parity_err(parity_err_np), .frame_err(frame_err_np), .overflow(overflow_np));

    always #5 clk = ~clk;

    // Count every cycle each error output is high; a two-cycle pulse shows up as 2.
    always @(negedge clk) begin
        if (parity_err) pe_n = pe_n + 1;
        if (frame_err)  fe_n = fe_n + 1;
        if (overflow)   ov_n = ov_n + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, then clock low for HALF cycles.
    // pop_k>0 raises rd_ready for exactly the cycle ending at negedge pop_k of the low phase.
    task automatic send_bit(input logic b, input bit glitch, input int pop_k, input bit meas);
        bit seen;
        seen = 1'b0;
        ps2_dat = b;
        if (glitch) begin
            tick(5);
            ps2_clk = 1'b0;
            tick(FL - 1);
            ps2_clk = 1'b1;
            tick(HALF - 5 - (FL - 1));
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (meas && !seen && rd_valid) begin
                lat  = i;
                seen = 1'b1;
            end
            if (pop_k > 0) rd_ready = (i == pop_k - 1);
        end
        if (pop_k > 0) rd_ready = 1'b0;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input int glitch_bit, input int pop_k, input bit meas);
        logic p;
        p = (~^d) ^ bad_par;
        send_bit(1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i, 0, 1'b0);
        send_bit(p, 1'b0, 0, 1'b0);
        send_bit(stop, 1'b0, pop_k, meas);
        ps2_dat = 1'b1;
        tick(10);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(3);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rd_data); end
        checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin
            failures++; $display("FAIL reset_errs got=%b exp=000", {parity_err, frame_err, overflow}); end
        areset = 1'b0;
        tick(3);
    endtask

    task automatic test_basic();
        int pe0, fe0, ov0;
        pe0 = pe_n; fe0 = fe_n; ov0 = ov_n;
        send_frame(8'h1C, 1'b0, 1'b1, -1, 0, 1'b1);
        checks++; if (lat < 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1..%0d", lat, HALF); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 8'h1C) begin failures++; $display("FAIL basic_data got=%h exp=1c", rd_data); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
        checks++; if ((pe_n - pe0) + (fe_n - fe0) + (ov_n - ov0) != 0) begin
            failures++; $display("FAIL basic_errs got=%0d exp=0", (pe_n - pe0) + (fe_n - fe0) + (ov_n - ov0)); end
        pop_one();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL basic_pop_count got=%0d exp=0", count); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_parity();
        int pe0;
        pe0 = pe_n;
        rd_ready_np = 1'b0;
        tick(2);
        send_frame(8'h1C, 1'b1, 1'b1, -1, 0, 1'b0);
        checks++; if (pe_n - pe0 != 1) begin failures++; $display("FAIL parity_pulse got=%0d exp=1", pe_n - pe0); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL parity_count got=%0d exp=0", count); end
        checks++; if (count_np !== 4'd1) begin failures++; $display("FAIL noparity_count got=%0d exp=1", count_np); end
        checks++; if (rd_data_np !== 8'h1C) begin failures++; $display("FAIL noparity_data got=%h exp=1c", rd_data_np); end
        checks++; if (parity_err_np !== 1'b0) begin failures++; $display("FAIL noparity_pulse got=%b exp=0", parity_err_np); end
        rd_ready_np = 1'b1;
        tick(2);
    endtask

    task automatic test_stop();
        int pe0, fe0;
        pe0 = pe_n; fe0 = fe_n;
        send_frame(8'hF0, 1'b0, 1'b0, -1, 0, 1'b0);
        checks++; if (fe_n - fe0 != 1) begin failures++; $display("FAIL stop_pulse got=%0d exp=1", fe_n - fe0); end
        checks++; if (pe_n - pe0 != 0) begin failures++; $display("FAIL stop_parity_pulse got=%0d exp=0", pe_n - pe0); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL stop_count got=%0d exp=0", count); end
        send_frame(8'hF0, 1'b0, 1'b1, -1, 0, 1'b0);
        checks++; if (rd_data !== 8'hF0 || count !== 4'd1) begin
            failures++; $display("FAIL stop_next got=%h/%0d exp=f0/1", rd_data, count); end
        pop_one();
    endtask

    task automatic test_timeout();
        int fe0;
        logic [7:0] d;
        d = 8'h5A;
        fe0 = fe_n;
        send_bit(1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0, 0, 1'b0);
        ps2_dat = 1'b1;
        tick(TMO + 50);
        checks++; if (fe_n - fe0 != 1) begin failures++; $display("FAIL timeout_pulse got=%0d exp=1", fe_n - fe0); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL timeout_count got=%0d exp=0", count); end
        send_frame(8'h5A, 1'b0, 1'b1, -1, 0, 1'b0);
        checks++; if (rd_data !== 8'h5A || count !== 4'd1) begin
            failures++; $display("FAIL timeout_next got=%h/%0d exp=5a/1", rd_data, count); end
        checks++; if (fe_n - fe0 != 1) begin failures++; $display("FAIL timeout_extra got=%0d exp=1", fe_n - fe0); end
        pop_one();
    endtask

    task automatic test_overflow();
        int ov0;
        ov0 = ov_n;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, -1, 0, 1'b0);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (ov_n - ov0 != 1) begin failures++; $display("FAIL ovf_pulse got=%0d exp=1", ov_n - ov0); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            pop_one();
        end
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, -1, 0, 1'b0);
        ov0 = ov_n;
        send_frame(8'h19, 1'b0, 1'b1, -1, lat, 1'b0);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_pushpop_count got=%0d exp=8", count); end
        checks++; if (ov_n - ov0 != 0) begin failures++; $display("FAIL full_pushpop_ovf got=%0d exp=0", ov_n - ov0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd_data !== 8'h12 + 8'(i)) begin
                failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, rd_data, 8'h12 + 8'(i)); end
            pop_one();
        end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", rd_valid); end
    endtask

    task automatic test_glitch();
        int pe0, fe0;
        pe0 = pe_n; fe0 = fe_n;
        send_frame(8'h3C, 1'b0, 1'b1, 3, 0, 1'b0);
        checks++; if (rd_data !== 8'h3C || count !== 4'd1) begin
            failures++; $display("FAIL glitch_data got=%h/%0d exp=3c/1", rd_data, count); end
        checks++; if ((pe_n - pe0) + (fe_n - fe0) != 0) begin
            failures++; $display("FAIL glitch_errs got=%0d exp=0", (pe_n - pe0) + (fe_n - fe0)); end
        pop_one();
    endtask

    task automatic test_areset_midframe();
        int fe0;
        logic [7:0] d;
        d = 8'h3A;
        send_frame(8'h77, 1'b0, 1'b1, -1, 0, 1'b0);
        send_bit(1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i], 1'b0, 0, 1'b0);
        areset = 1'b1;
        tick(2);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL ares_count got=%0d exp=0", count); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            failures++; $display("FAIL ares_out got=%b/%h exp=0/00", rd_valid, rd_data); end
        areset = 1'b0;
        tick(3);
        fe0 = fe_n;
        send_bit(1'b1, 1'b0, 0, 1'b0);
        tick(10);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL ares_spurious got=%0d exp=0", count); end
        send_frame(8'h3A, 1'b0, 1'b1, -1, 0, 1'b0);
        checks++; if (rd_data !== 8'h3A || count !== 4'd1) begin
            failures++; $display("FAIL ares_next got=%h/%0d exp=3a/1", rd_data, count); end
        checks++; if (fe_n - fe0 != 0) begin failures++; $display("FAIL ares_ferr got=%0d exp=0", fe_n - fe0); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_timeout();
        test_overflow();
        test_glitch();
        test_areset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver running in the system clock domain. It synchronises and deglitches ps2_clk and ps2_dat, then deserialises 11-bit frames. Each frame is checked for start bit, odd parity and stop bit, and recovers from stalled frames by timeout. Good bytes are buffered in a first-word-fall-through FIFO with a valid/ready read port, for consumption by the scan-code decoder.

Parameters:
FILTER_LEN, 8, number of consecutive clk cycles the synchronised ps2_clk must hold a new level before the filtered clock changes (>=2)
TIMEOUT_CYC, 50000, clk cycles allowed between two sample events inside a frame before the frame is aborted
FIFO_DEPTH, 8, byte capacity of the receive FIFO; must be a power of two, >=2
CHECK_PARITY, 1, 1 = reject frames with bad parity; 0 = parity bit ignored

Ports:
clk  input  1  system clock; all logic is on its rising edge
areset  input  1  reset, asynchronous, active-high
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_dat  input  1  raw PS/2 data line, asynchronous
rd_data  output  8  byte at FIFO head; valid only while rd_valid=1
rd_valid  output  1  FIFO not empty
rd_ready  input  1  consumer accepts rd_data; a pop occurs when rd_valid & rd_ready
count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored
parity_err  output  1  one-cycle pulse: frame dropped for bad parity
frame_err  output  1  one-cycle pulse: frame dropped for bad stop bit or timeout
overflow  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset:
  - All outputs are 0 and the FIFO is empty.
  - FSM is in IDLE; bit counter and timeout counter are 0.
  - Synchroniser flops and filtered clock reset to 1 (bus idle high).
- Input conditioning:
  - Each input passes through a 2-flop synchroniser.
  - Filtered clock flips only after the synchronised ps2_clk differs from it for FILTER_LEN consecutive clk cycles; any agreement restarts the run count.
- Sample event: a 1->0 transition of the filtered clock. The synchronised ps2_dat is sampled in the same cycle.
- FSM (advances only on sample events, except for timeout):
  - IDLE: dat=0 -> DATA with bit count 0; dat=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift LSB-first into an 8-bit register; after the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP:
    - dat=0: frame_err.
    - Else, CHECK_PARITY=1 and ones(data)+parity is even: parity_err.
    - Else: push data.
    - In all cases -> IDLE.
  - Stop-bit fault takes priority: at most one error pulse per frame.
- Timeout:
  - The counter clears on every sample event and increments each clk cycle while in DATA, PARITY or STOP.
  - Reaching TIMEOUT_CYC-1 -> frame_err pulse, partial data discarded, -> IDLE.
  - Timeout is not active in IDLE.
- FIFO:
  - Push happens in the clk cycle of the stop-bit sample event; rd_valid/rd_data/count update on the next cycle.
  - Pop: head advances on the cycle after rd_valid & rd_ready.
  - Push while full with no pop in that cycle: byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle: both occur, including when full; count unchanged.
  - rd_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH; count spans 0..FIFO_DEPTH.
- Error pulses are exactly one clk wide and may coincide with a pop.
- areset mid-frame: partial frame discarded and FIFO emptied immediately. After release, the next falling edge with dat=1 is ignored; bytes are received only after a fresh start bit.

Test Plan:
- Defaults, one frame 0x1C (bits LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1), rd_ready=0 -> rd_valid=1, rd_data=0x1C, count=1, no error pulses; raise rd_ready for one cycle -> count=0, rd_valid=0.
- Frame 0x1C with parity bit 1 -> single parity_err pulse, count stays 0. Repeat with CHECK_PARITY=0 -> 0x1C stored, no pulse.
- Frame 0xF0 with stop bit 0 -> single frame_err pulse, no push. Next correct frame 0xF0 -> stored normally.
- Start bit plus 4 data bits, then lines held high for TIMEOUT_CYC cycles -> frame_err pulse and FSM in IDLE. Next full frame 0x5A -> rd_data=0x5A.
- rd_ready=0, 9 frames 0x01..0x09 -> count=8, one overflow pulse on the 9th frame. Drain -> 0x01..0x08 in order. Then push and pop in the same cycle while full -> count stays 8.
- ps2_clk low glitch of FILTER_LEN-1 cycles inside a frame -> no extra bit sampled, frame decodes correctly. areset asserted after 5 data bits -> outputs 0; a following clean frame 0x3A is received.
